dds_sample_sequencer: RTL and testbench

//  Upstream stage of the interpolator: phase accumulator plus segment timer. Every 10^Mode Fg_CLK

---
 rtl/dds_pkg.sv | 36 +++
 rtl/dds_tick_gen.sv | 51 +++++
 rtl/dds_sample_sequencer.sv | 105 ++++++++++
 tb/tb_dds_sample_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg
//   Shared constants and helpers for the DDS sample sequencer and the
//   downstream interpolator.
//   - SAMPLE_LSB / SAMPLE_W : where a ROM sample sits inside a 32-bit word
//   - MODE_MAX              : largest honoured interpolation decade
//   - decade_period()       : segment length in Fg_CLK cycles for a decade
//   - sample_to_word()      : places a ROM sample into the 32-bit format
package dds_pkg;

    localparam int SAMPLE_LSB = 18;
    localparam int SAMPLE_W   = 12;
    localparam int MODE_MAX   = 4;
    localparam int ADDR_W     = 10;
    localparam int CNT_W      = 14;

    // Decades above 4 saturate at 10^4 so the 14-bit counter can never overflow.
    function automatic logic [CNT_W-1:0] decade_period(input logic [3:0] mode);
        logic [CNT_W-1:0] p;
        case (mode)
            4'd0:    p = CNT_W'(1);
            4'd1:    p = CNT_W'(10);
            4'd2:    p = CNT_W'(100);
            4'd3:    p = CNT_W'(1000);
            default: p = CNT_W'(10000);
        endcase
        return p;
    endfunction

    function automatic logic [31:0] sample_to_word(input logic [SAMPLE_W-1:0] sample);
        logic [31:0] word;
        word = '0;
        word[SAMPLE_LSB +: SAMPLE_W] = sample;
        return word;
    endfunction

endpackage

// File: rtl/dds_tick_gen.sv
// dds_tick_gen
//   Segment timer. Issues one tick every 10^min(Mode,MODE_MAX) cycles while
//   Run is high, and a tick immediately on a Run rising edge.
//   Ports:
//     clk_i      clock (Fg_CLK)
//     rst_n_i    asynchronous active-low reset
//     run_i      enable tick generation; counter holds while low
//     mode_i     interpolation decade, sampled only at a tick (reload)
//     tick_o     1-cycle tick, combinational from state and run_i
//     restart_o  Run rising edge (coincides with a tick)
module dds_tick_gen
    import dds_pkg::*;
#(
    parameter int MODE_MAX_P = dds_pkg::MODE_MAX
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       run_i,
    input  logic [3:0] mode_i,
    output logic       tick_o,
    output logic       restart_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             run_q;
    logic [3:0]       mode_clamped;

    always_comb begin
        mode_clamped = (mode_i > 4'(MODE_MAX_P)) ? 4'(MODE_MAX_P) : mode_i;
        restart_o    = run_i & ~run_q;
        // A restart forces a tick regardless of where the counter was frozen.
        tick_o       = run_i & (restart_o | (count_q == '0));
        count_d      = count_q;
        if (tick_o) begin
            count_d = decade_period(mode_clamped) - CNT_W'(1);
        end else if (run_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_i;
        end
    end

endmodule

// File: rtl/dds_sample_sequencer.sv
// dds_sample_sequencer
//   Phase accumulator, sine ROM fetch and sample-pair output for the
//   interpolator. Each tick advances the phase by FTW and fetches one sample;
//   the newest sample appears on out1 and the previous one on out2, flagged
//   by a 1-cycle Enable pulse.
//   Ports:
//     Fg_CLK    clock
//     RESETn    asynchronous active-low reset
//     Run       1 = generate segments
//     FTW       phase increment per segment
//     Mode      interpolation decade (segment = 10^Mode cycles, clamped)
//     rom_addr  sync sine ROM address (registered)
//     rom_data  ROM data, valid one cycle after rom_addr
//     out1      newest sample word
//     out2      previous sample word
//     Enable    out1/out2 hold a new valid pair
module dds_sample_sequencer
    import dds_pkg::*;
#(
    parameter int ADDR_W   = dds_pkg::ADDR_W,
    parameter int MODE_MAX = dds_pkg::MODE_MAX
) (
    input  logic                Fg_CLK,
    input  logic                RESETn,
    input  logic                Run,
    input  logic [31:0]         FTW,
    input  logic [3:0]          Mode,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_data,
    output logic [31:0]         out1,
    output logic [31:0]         out2,
    output logic                Enable
);

    logic              tick, restart;
    logic [31:0]       phase_q, phase_d, phase_base;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              v1_q, v2_q;
    logic [1:0]        prime_q, prime_d;
    logic [31:0]       out1_q, out1_d, out2_q, out2_d;
    logic              enable_q, enable_d;

    dds_tick_gen #(
        .MODE_MAX_P (MODE_MAX)
    ) u_tick_gen (
        .clk_i     (Fg_CLK),
        .rst_n_i   (RESETn),
        .run_i     (Run),
        .mode_i    (Mode),
        .tick_o    (tick),
        .restart_o (restart)
    );

    always_comb begin
        // On restart the tick addresses phase 0 and the accumulator continues from FTW.
        phase_base = restart ? '0 : phase_q;
        phase_d    = phase_q;
        rom_addr_d = rom_addr_q;
        out1_d     = out1_q;
        out2_d     = out2_q;
        prime_d    = prime_q;
        if (tick) begin
            rom_addr_d = phase_base[31 -: ADDR_W];
            phase_d    = phase_base + FTW;
        end
        if (v2_q) begin
            out2_d  = out1_q;
            out1_d  = sample_to_word(rom_data);
            prime_d = (prime_q == 2'd2) ? 2'd2 : prime_q + 2'd1;
        end
        if (restart) begin
            prime_d = 2'd0;
        end
        // The first sample after a restart has no valid predecessor in out2.
        enable_d = v2_q & (prime_q != 2'd0);
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            phase_q    <= '0;
            rom_addr_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            prime_q    <= 2'd0;
            out1_q     <= '0;
            out2_q     <= '0;
            enable_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            rom_addr_q <= rom_addr_d;
            v1_q       <= tick;
            v2_q       <= v1_q;
            prime_q    <= prime_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            enable_q   <= enable_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign out1     = out1_q;
    assign out2     = out2_q;
    assign Enable   = enable_q;

endmodule

// File: tb/tb_dds_sample_sequencer.sv
// tb_dds_sample_sequencer
//   Directed bench for dds_sample_sequencer. The ROM model returns
//   addr + 0x100 one cycle after the address.
module tb_dds_sample_sequencer;

    logic        Fg_CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        Run    = 1'b0;
    logic [31:0] FTW    = '0;
    logic [3:0]  Mode   = '0;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic [31:0] out1, out2;
    logic        Enable;

    int passed = 0;
    int total  = 0;

    dds_sample_sequencer dut (
        .Fg_CLK   (Fg_CLK),
        .RESETn   (RESETn),
        .Run      (Run),
        .FTW      (FTW),
        .Mode     (Mode),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out1     (out1),
        .out2     (out2),
        .Enable   (Enable)
    );

    initial forever #5 Fg_CLK = ~Fg_CLK;

    always @(posedge Fg_CLK) rom_data <= {2'b00, rom_addr} + 12'h100;

    function automatic logic [31:0] w(input int addr);
        return (32'(addr) + 32'h100) << 18;
    endfunction

    task automatic step();
        @(posedge Fg_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_enable(input int max_cycles, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (Enable !== 1'b1 && n < max_cycles);
    endtask

    task automatic stop_run();
        Run = 1'b0;
        idle(6);
    endtask

    task automatic test_reset();
        #1;
        total++; if (out1 !== 32'd0)  $display("FAIL rst_out1 got %h exp 0", out1); else passed++;
        total++; if (out2 !== 32'd0)  $display("FAIL rst_out2 got %h exp 0", out2); else passed++;
        total++; if (Enable !== 1'b0) $display("FAIL rst_enable got %b exp 0", Enable); else passed++;
        total++; if (rom_addr !== 10'd0) $display("FAIL rst_addr got %0d exp 0", rom_addr); else passed++;
        idle(2);
        RESETn = 1'b1;
    endtask

    task automatic test_mode1();
        int n;
        Mode = 4'd1; FTW = 32'h0400_0000; Run = 1'b1;
        step();
        total++; if (rom_addr !== 10'd0) $display("FAIL m1_addr0 got %0d exp 0", rom_addr); else passed++;
        wait_enable(100, n);
        total++; if (n + 1 !== 13) $display("FAIL m1_first_en got %0d exp 13", n + 1); else passed++;
        total++; if (out2 !== w(0))  $display("FAIL m1_out2 got %h exp %h", out2, w(0)); else passed++;
        total++; if (out1 !== w(16)) $display("FAIL m1_out1 got %h exp %h", out1, w(16)); else passed++;
        wait_enable(100, n);
        total++; if (n !== 10) $display("FAIL m1_period got %0d exp 10", n); else passed++;
        total++; if (rom_addr !== 10'd32) $display("FAIL m1_addr32 got %0d exp 32", rom_addr); else passed++;
        total++; if (out1 !== w(32)) $display("FAIL m1_out1b got %h exp %h", out1, w(32)); else passed++;
        total++; if (out2 !== w(16)) $display("FAIL m1_out2b got %h exp %h", out2, w(16)); else passed++;
        step();
        total++; if (Enable !== 1'b0) $display("FAIL m1_pulse got %b exp 0", Enable); else passed++;
        stop_run();
    endtask

    task automatic test_back_to_back();
        int n;
        Mode = 4'd0; FTW = 32'h0040_0000; Run = 1'b1;
        idle(3);
        total++; if (Enable !== 1'b0) $display("FAIL b2b_prime got %b exp 0", Enable); else passed++;
        step();
        total++; if (Enable !== 1'b1) $display("FAIL b2b_first got %b exp 1", Enable); else passed++;
        total++; if (out1 !== w(1)) $display("FAIL b2b_out1 got %h exp %h", out1, w(1)); else passed++;
        total++; if (out2 !== w(0)) $display("FAIL b2b_out2 got %h exp %h", out2, w(0)); else passed++;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++;
            if (Enable !== 1'b1 || out1 !== w(1 + i))
                $display("FAIL b2b_stream%0d got en=%b out1=%h exp en=1 out1=%h", i, Enable, out1, w(1 + i));
            else passed++;
        end
        // Asynchronous reset in the middle of a cycle while streaming.
        #2;
        RESETn = 1'b0;
        #1;
        total++; if (out1 !== 32'd0)  $display("FAIL midrst_out1 got %h exp 0", out1); else passed++;
        total++; if (out2 !== 32'd0)  $display("FAIL midrst_out2 got %h exp 0", out2); else passed++;
        total++; if (Enable !== 1'b0) $display("FAIL midrst_en got %b exp 0", Enable); else passed++;
        total++; if (rom_addr !== 10'd0) $display("FAIL midrst_addr got %0d exp 0", rom_addr); else passed++;
        step();
        RESETn = 1'b1;
        wait_enable(20, n);
        total++; if (n !== 4) $display("FAIL midrst_reprime got %0d exp 4", n); else passed++;
        total++; if (out2 !== w(0)) $display("FAIL midrst_out2b got %h exp %h", out2, w(0)); else passed++;
        total++; if (out1 !== w(1)) $display("FAIL midrst_out1b got %h exp %h", out1, w(1)); else passed++;
        stop_run();
    endtask

    task automatic test_mode_change();
        int n;
        Mode = 4'd2; FTW = 32'h0040_0000; Run = 1'b1;
        wait_enable(200, n);
        total++; if (n !== 103) $display("FAIL mc_first got %0d exp 103", n); else passed++;
        Mode = 4'd3;
        wait_enable(200, n);
        total++; if (n !== 100) $display("FAIL mc_old_seg got %0d exp 100", n); else passed++;
        wait_enable(1100, n);
        total++; if (n !== 1000) $display("FAIL mc_new_seg got %0d exp 1000", n); else passed++;
        total++; if (out1 !== w(3)) $display("FAIL mc_out1 got %h exp %h", out1, w(3)); else passed++;
        total++; if (out2 !== w(2)) $display("FAIL mc_out2 got %h exp %h", out2, w(2)); else passed++;
        stop_run();
    endtask

    task automatic test_clamp();
        int n;
        Mode = 4'd7; FTW = 32'hF000_0000; Run = 1'b1;
        step();
        total++; if (rom_addr !== 10'd0) $display("FAIL cl_addr0 got %0d exp 0", rom_addr); else passed++;
        wait_enable(10100, n);
        total++; if (n + 1 !== 10003) $display("FAIL cl_first got %0d exp 10003", n + 1); else passed++;
        total++; if (rom_addr !== 10'd960) $display("FAIL cl_addr960 got %0d exp 960", rom_addr); else passed++;
        total++; if (out1 !== w(960)) $display("FAIL cl_out1 got %h exp %h", out1, w(960)); else passed++;
        total++; if (out2 !== w(0))   $display("FAIL cl_out2 got %h exp %h", out2, w(0)); else passed++;
        wait_enable(10100, n);
        total++; if (n !== 10000) $display("FAIL cl_period got %0d exp 10000", n); else passed++;
        total++; if (rom_addr !== 10'd896) $display("FAIL cl_addr896 got %0d exp 896", rom_addr); else passed++;
        total++; if (out1 !== w(896)) $display("FAIL cl_out1b got %h exp %h", out1, w(896)); else passed++;
        total++; if (out2 !== w(960)) $display("FAIL cl_out2b got %h exp %h", out2, w(960)); else passed++;
        stop_run();
    endtask

    task automatic test_run_stop();
        int n;
        Mode = 4'd1; FTW = 32'h0400_0000; Run = 1'b1;
        wait_enable(100, n);
        total++; if (n !== 13) $display("FAIL rs_first got %0d exp 13", n); else passed++;
        idle(8);
        Run = 1'b0;
        wait_enable(50, n);
        total++; if (n !== 2) $display("FAIL rs_last got %0d exp 2", n); else passed++;
        total++; if (out1 !== w(32)) $display("FAIL rs_out1 got %h exp %h", out1, w(32)); else passed++;
        wait_enable(60, n);
        total++;
        if (n !== 60 || Enable !== 1'b0) $display("FAIL rs_quiet got %0d en=%b exp 60 en=0", n, Enable);
        else passed++;
        Run = 1'b1;
        wait_enable(100, n);
        total++; if (n !== 13) $display("FAIL rs_reprime got %0d exp 13", n); else passed++;
        total++; if (out2 !== w(0))  $display("FAIL rs_out2 got %h exp %h", out2, w(0)); else passed++;
        total++; if (out1 !== w(16)) $display("FAIL rs_out1b got %h exp %h", out1, w(16)); else passed++;
        stop_run();
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_back_to_back();
        test_mode_change();
        test_clamp();
        test_run_stop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
